// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save stream accumulator.
//   state_e : accumulator FSM states (accumulate / resolve / hold result)
//   acc_w   : accumulator width helper, WIDTH + GUARD
//   extend  : zero- or sign-extension of an operand up to MaxW bits
package csa_pkg;

  typedef enum logic [1:0] {
    StAccum   = 2'd0,
    StResolve = 2'd1,
    StHold    = 2'd2
  } state_e;

  // Widest accumulator the extend helper supports.
  localparam int unsigned MaxW = 64;

  function automatic int unsigned acc_w(input int unsigned width, input int unsigned guard);
    return width + guard;
  endfunction

  // Extend the low w bits of v to MaxW bits; sgn selects sign extension.
  function automatic logic [MaxW-1:0] extend(input logic [MaxW-1:0] v, input int unsigned w,
                                             input logic sgn);
    logic [MaxW-1:0] mask;
    logic            msb;
    mask = (w >= MaxW) ? '1 : ((MaxW'(1) << w) - MaxW'(1));
    msb  = |(v & (MaxW'(1) << (w - 1)));
    return (v & mask) | ((sgn && msb) ? ~mask : '0);
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// W parallel full adders compressing three vectors into a sum and an unshifted carry.
//   a, b, c : addends
//   sum     : bitwise sum
//   carry   : bitwise majority (weight 2, caller shifts it)
module csa_3to2 #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming three-operand accumulator. Beats are folded into a redundant (sum, carry)
// pair with three carry-save levels; a single carry-propagate add resolves the pair at
// frame end and the result is held until downstream accepts it.
//   clk, rst_n                       : clock, synchronous active-low reset
//   in_valid/in_ready/in_last        : input beat handshake, frame end marker
//   in_x, in_y, in_z                 : operands (WIDTH bits)
//   out_valid/out_ready              : result handshake
//   out_result                       : frame sum modulo 2^ACC_W
//   out_count                        : beats in the frame, saturating
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned GUARD  = 6,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned CNT_W  = 8,
  localparam int unsigned AccW  = acc_w(WIDTH, GUARD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AccW-1:0]  out_result,
  output logic [CNT_W-1:0] out_count
);

  state_e state_q, state_d;

  logic [AccW-1:0]  sum_q, carry_q, result_q;
  logic [CNT_W-1:0] count_q, rcount_q;

  logic [AccW-1:0] x_ext, y_ext, z_ext;
  logic [AccW-1:0] s1, c1, s2, c2, s3, c3;
  logic [AccW-1:0] c1_sh, c2_sh, c3_sh;
  logic            beat;

  assign x_ext = AccW'(extend(MaxW'(in_x), WIDTH, SIGNED != 0));
  assign y_ext = AccW'(extend(MaxW'(in_y), WIDTH, SIGNED != 0));
  assign z_ext = AccW'(extend(MaxW'(in_z), WIDTH, SIGNED != 0));

  // Invariant: sum_q + carry_q equals the running total, so every level only has to
  // preserve the sum of its three inputs.
  csa_3to2 #(.W(AccW)) u_lvl1 (.a(x_ext), .b(y_ext), .c(z_ext), .sum(s1), .carry(c1));
  assign c1_sh = {c1[AccW-2:0], 1'b0};

  csa_3to2 #(.W(AccW)) u_lvl2 (.a(s1), .b(c1_sh), .c(sum_q), .sum(s2), .carry(c2));
  assign c2_sh = {c2[AccW-2:0], 1'b0};

  csa_3to2 #(.W(AccW)) u_lvl3 (.a(s2), .b(c2_sh), .c(carry_q), .sum(s3), .carry(c3));
  assign c3_sh = {c3[AccW-2:0], 1'b0};

  assign beat = (state_q == StAccum) && in_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StAccum:   if (in_valid && in_last) state_d = StResolve;
      StResolve: state_d = StHold;
      StHold:    if (out_ready) state_d = StAccum;
      default:   state_d = StAccum;
    endcase
  end

  // Outputs decode the registered state only, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StAccum: in_ready  = 1'b1;
      StHold:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Redundant accumulator, beat counter and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q    <= '0;
      carry_q  <= '0;
      count_q  <= '0;
      result_q <= '0;
      rcount_q <= '0;
    end else if (beat) begin
      sum_q   <= s3;
      carry_q <= c3_sh;
      if (count_q != '1) count_q <= count_q + CNT_W'(1);
    end else if (state_q == StResolve) begin
      result_q <= sum_q + carry_q;
      rcount_q <= count_q;
      sum_q    <= '0;
      carry_q  <= '0;
      count_q  <= '0;
    end
  end

  assign out_result = result_q;
  assign out_count  = rcount_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed bench: three accumulator instances (unsigned ACC_W=10, unsigned ACC_W=6,
// signed ACC_W=10) share one input stream; a scoreboard holds the expected frame results.
module tb_csa_stream_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_x = '0, in_y = '0, in_z = '0;

  logic       rdy_u, rdy_w, rdy_s;
  logic       ov_u, ov_w, ov_s;
  logic [9:0] res_u, res_s;
  logic [5:0] res_w;
  logic [7:0] cnt_u, cnt_w, cnt_s;

  always #5 clk = ~clk;

  csa_stream_accumulator #(.WIDTH(4), .GUARD(6), .SIGNED(0), .CNT_W(8)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_u), .in_last(in_last),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(ov_u), .out_ready(out_ready),
    .out_result(res_u), .out_count(cnt_u)
  );

  csa_stream_accumulator #(.WIDTH(4), .GUARD(2), .SIGNED(0), .CNT_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w), .in_last(in_last),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(ov_w), .out_ready(out_ready),
    .out_result(res_w), .out_count(cnt_w)
  );

  csa_stream_accumulator #(.WIDTH(4), .GUARD(6), .SIGNED(1), .CNT_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s), .in_last(in_last),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(ov_s), .out_ready(out_ready),
    .out_result(res_s), .out_count(cnt_s)
  );

  typedef struct {
    logic [9:0] ru;
    logic [5:0] rw;
    logic [9:0] rs;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   sum_u = 0;
  int   sum_s = 0;
  int   cnt_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sx4(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  task automatic model_clear();
    sum_u = 0;
    sum_s = 0;
    cnt_m = 0;
  endtask

  // Offer a beat, wait (bounded) for acceptance, update the model.
  task automatic send(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z,
                      input logic last);
    int   n;
    exp_t e;
    n = 0;
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    in_z = z;
    in_last = last;
    while (!rdy_u && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(rdy_u), 32'd1);
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
    sum_u += int'(x) + int'(y) + int'(z);
    sum_s += sx4(x) + sx4(y) + sx4(z);
    if (cnt_m < 255) cnt_m++;
    if (last) begin
      e.ru = sum_u[9:0];
      e.rw = sum_u[5:0];
      e.rs = sum_s[9:0];
      e.cnt = cnt_m[7:0];
      sb.push_back(e);
      model_clear();
    end
  endtask

  // Wait for a result, compare, optionally stall hold cycles, then accept it.
  task automatic collect(input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!ov_u && n < 20) begin
      step();
      n++;
    end
    check("out_valid_seen", 32'(ov_u), 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("res_u", 32'(res_u), 32'(e.ru));
    check("res_w", 32'(res_w), 32'(e.rw));
    check("res_s", 32'(res_s), 32'(e.rs));
    check("cnt_u", 32'(cnt_u), 32'(e.cnt));
    check("cnt_w", 32'(cnt_w), 32'(e.cnt));
    check("cnt_s", 32'(cnt_s), 32'(e.cnt));
    check("ov_ws", 32'({ov_w, ov_s}), 32'b11);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      step();
      check("bp_valid", 32'(ov_u), 32'd1);
      check("bp_ready", 32'(rdy_u), 32'd0);
      check("bp_result", 32'(res_u), 32'(e.ru));
      check("bp_count", 32'(cnt_u), 32'(e.cnt));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_in_ready", 32'({rdy_u, rdy_w, rdy_s}), 32'b111);
    check("post_out_valid", 32'({ov_u, ov_w, ov_s}), 32'b000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    rst_n = 1'b0;
    step();
    step();
    check("rst_in_ready", 32'({rdy_u, rdy_w, rdy_s}), 32'b111);
    check("rst_out_valid", 32'({ov_u, ov_w, ov_s}), 32'b000);
    check("rst_result", 32'({res_u, res_w, res_s}), 32'd0);
    check("rst_count", 32'({cnt_u, cnt_w, cnt_s}), 32'd0);
    rst_n = 1'b1;
    step();

    // Single beat: 15+15+15 = 45 (signed -3); result appears two edges after acceptance
    send(4'd15, 4'd15, 4'd15, 1'b1);
    check("lat_resolve_valid", 32'(ov_u), 32'd0);
    check("lat_resolve_ready", 32'(rdy_u), 32'd0);
    step();
    check("lat_hold_valid", 32'(ov_u), 32'd1);
    collect(0);

    // Three beats of (1,2,3) with an idle gap after the first: 18
    send(4'd1, 4'd2, 4'd3, 1'b0);
    step();
    step();
    send(4'd1, 4'd2, 4'd3, 1'b0);
    send(4'd1, 4'd2, 4'd3, 1'b1);
    collect(0);

    // Two beats of (15,15,15): 90, wraps to 26 with ACC_W=6
    send(4'd15, 4'd15, 4'd15, 1'b0);
    send(4'd15, 4'd15, 4'd15, 1'b1);
    collect(0);

    // Signed (-1,-8,7) = -2, with five cycles of backpressure
    send(4'hF, 4'h8, 4'h7, 1'b1);
    collect(5);

    // Signed (-1,-1,-1) = -3
    send(4'hF, 4'hF, 4'hF, 1'b1);
    collect(0);

    // Reset mid-frame discards partial sums and the stale result registers
    send(4'd5, 4'd5, 4'd5, 1'b0);
    send(4'd5, 4'd5, 4'd5, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    check("midrst_out_valid", 32'({ov_u, ov_w, ov_s}), 32'b000);
    check("midrst_result", 32'({res_u, res_w, res_s}), 32'd0);
    check("midrst_count", 32'({cnt_u, cnt_w, cnt_s}), 32'd0);
    model_clear();
    rst_n = 1'b1;
    step();
    send(4'd1, 4'd0, 4'd0, 1'b1);
    collect(0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
